// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the synchronous FIFO.
//   ptr_w()        : pointer/occupancy width for a given depth (clog2(depth)+1)
//   AE_LVL_DEF     : default almost-empty level
//   AF_MARGIN_DEF  : default almost-full margin (AF_LVL = DEPTH - margin)
//   status_t       : registered status flags
//   ST_RESET       : status value after reset or clr
package fifo_pkg;

   localparam int AE_LVL_DEF    = 4;
   localparam int AF_MARGIN_DEF = 4;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic almost_empty;
      logic ovf;
      logic udf;
   } status_t;

   localparam status_t ST_RESET = '{empty: 1'b1, full: 1'b0, almost_full: 1'b0,
                                    almost_empty: 1'b1, ovf: 1'b0, udf: 1'b0};

   // The extra MSB lets head == tail mean empty and a differing MSB mean full.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram -- simple dual-port storage, WBITS x DEPTH.
//   clk            : clock, rising edge
//   rst_n          : async active-low reset, read data register only
//   we/waddr/wdata : synchronous write port
//   re/raddr       : read port; rdata is registered and holds when re=0
// A read and a write to the same address in one cycle return the old word.
module fifo_ram #(
   parameter int WBITS = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WBITS-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WBITS-1:0]         rdata
);

   logic [WBITS-1:0] mem [DEPTH];

   // The array itself is never reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with occupancy count and sticky error flags.
//   clk, rst_n     : clock (rising edge), async active-low reset
//   clr            : synchronous flush of pointers, count and sticky flags
//   wr_en, din     : write request and data
//   rd_en          : read request (pop)
//   dout, dout_vld : read data and its valid indication
//   empty, full, almost_full, almost_empty : registered status
//   cnt            : occupancy 0..DEPTH
//   ovf, udf       : sticky refused-write / refused-read flags
// Build option FIFO_FWFT_EN: first-word-fall-through output (dout shows the
// oldest word while empty=0, rd_en pops it). Undefined: standard mode, dout
// updates one cycle after an accepted read and dout_vld pulses with it.
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int WBITS  = 8,
   parameter int DEPTH  = 4096,
   parameter int AF_LVL = DEPTH - AF_MARGIN_DEF,
   parameter int AE_LVL = AE_LVL_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic [WBITS-1:0]        din,
   input  logic                    rd_en,
   output logic [WBITS-1:0]        dout,
   output logic                    dout_vld,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [ptr_w(DEPTH)-1:0] cnt,
   output logic                    ovf,
   output logic                    udf
);

   localparam int            CW      = ptr_w(DEPTH);
   localparam int            AW      = CW - 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

   logic [CW-1:0]    head, tail, cnt_q;
   logic [CW-1:0]    head_nxt, tail_nxt, cnt_nxt;
   status_t          st_q, st_nxt;
   logic             wr_acc, rd_acc;
   logic             ram_pop;   // advance tail / issue a RAM read this cycle
   logic             vld_nxt;   // a readable word exists after this edge
   logic [WBITS-1:0] ram_rdata;

   // Handshake: a write is taken when wr_en=1 and (full=0 or a read is taken in
   // the same cycle); a read is taken when rd_en=1 and empty=0. A request that
   // is not taken is dropped and sets the matching sticky flag (ovf / udf).
   always_comb begin
      rd_acc = rd_en && !st_q.empty;
      wr_acc = wr_en && (!st_q.full || rd_acc);
   end

   always_comb begin
      cnt_nxt = cnt_q;
      if (wr_acc && !rd_acc)      cnt_nxt = cnt_q + CW'(1);
      else if (rd_acc && !wr_acc) cnt_nxt = cnt_q - CW'(1);
   end

`ifdef FIFO_FWFT_EN
   // RAM occupancy excludes the word parked in the RAM output register.
   logic [CW-1:0] ram_cnt;
   assign ram_cnt  = head - tail;
   // Refill the output register whenever it is empty or being popped.
   assign ram_pop  = (ram_cnt != '0) && (st_q.empty || rd_acc);
   assign vld_nxt  = ram_pop || (!st_q.empty && !rd_acc);
   assign dout_vld = !st_q.empty;
`else
   logic dv_q;
   assign ram_pop  = rd_acc;
   assign vld_nxt  = (cnt_nxt != '0);
   assign dout_vld = dv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   dv_q <= 1'b0;
      else if (clr) dv_q <= 1'b0;
      else          dv_q <= rd_acc;
   end
`endif

   always_comb begin
      head_nxt            = head + {{(CW-1){1'b0}}, wr_acc};
      tail_nxt            = tail + {{(CW-1){1'b0}}, ram_pop};
      st_nxt.empty        = !vld_nxt;
      st_nxt.full         = (cnt_nxt == DEPTH_C);
      st_nxt.almost_full  = (cnt_nxt >= AF_C);
      st_nxt.almost_empty = (cnt_nxt <= AE_C);
      st_nxt.ovf          = st_q.ovf || (wr_en && !wr_acc);
      st_nxt.udf          = st_q.udf || (rd_en && !rd_acc);
   end

   // clr wins over any request in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
         st_q  <= ST_RESET;
      end else if (clr) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
         st_q  <= ST_RESET;
      end else begin
         head  <= head_nxt;
         tail  <= tail_nxt;
         cnt_q <= cnt_nxt;
         st_q  <= st_nxt;
      end
   end

   fifo_ram #(
      .WBITS (WBITS),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc && !clr),
      .waddr (head[AW-1:0]),
      .wdata (din),
      .re    (ram_pop && !clr),
      .raddr (tail[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign dout         = ram_rdata;
   assign empty        = st_q.empty;
   assign full         = st_q.full;
   assign almost_full  = st_q.almost_full;
   assign almost_empty = st_q.almost_empty;
   assign ovf          = st_q.ovf;
   assign udf          = st_q.udf;
   assign cnt          = cnt_q;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync -- bench for fifo_sync with WBITS=8, DEPTH=16, AF_LVL=14, AE_LVL=2.
module tb_fifo_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       wr_en;
   logic [7:0] din;
   logic       rd_en;
   logic [7:0] dout;
   logic       dout_vld;
   logic       empty, full, almost_full, almost_empty;
   logic [4:0] cnt;
   logic       ovf, udf;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard / reference model state
   logic [7:0] exp_q[$];
   logic [7:0] exp_dout;
   logic       exp_dv;
   logic       m_ovf, m_udf;

   fifo_sync #(.WBITS(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .dout_vld     (dout_vld),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .cnt          (cnt),
      .ovf          (ovf),
      .udf          (udf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_dv = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = exp_q.size();
      chk({tag, ".cnt"},   32'(cnt),          32'(n));
      chk({tag, ".empty"}, 32'(empty),        32'(n == 0));
      chk({tag, ".full"},  32'(full),         32'(n == 16));
      chk({tag, ".af"},    32'(almost_full),  32'(n >= 14));
      chk({tag, ".ae"},    32'(almost_empty), 32'(n <= 2));
      chk({tag, ".ovf"},   32'(ovf),          32'(m_ovf));
      chk({tag, ".udf"},   32'(udf),          32'(m_udf));
      chk({tag, ".dv"},    32'(dout_vld),     32'(exp_dv));
      chk({tag, ".dout"},  32'(dout),         32'(exp_dout));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".cnt"},   32'(cnt),          32'd0);
      chk({tag, ".empty"}, 32'(empty),        32'd1);
      chk({tag, ".ae"},    32'(almost_empty), 32'd1);
      chk({tag, ".full"},  32'(full),         32'd0);
      chk({tag, ".af"},    32'(almost_full),  32'd0);
      chk({tag, ".dout"},  32'(dout),         32'd0);
      chk({tag, ".dv"},    32'(dout_vld),     32'd0);
      chk({tag, ".ovf"},   32'(ovf),          32'd0);
      chk({tag, ".udf"},   32'(udf),          32'd0);
   endtask

   // ---------------- driver tasks ----------------
   // One clock with the given requests; inputs change and outputs are sampled
   // 1 ns after the rising edge. The model follows standard-mode behaviour.
   task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
      logic rd_ok, wr_ok;
      wr_en = wr;
      din   = d;
      rd_en = rd;
      rd_ok = rd && (exp_q.size() != 0);
      wr_ok = wr && ((exp_q.size() < 16) || rd_ok);
      @(posedge clk);
      #1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      exp_dv = rd_ok;
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_udf = 1'b1;
   endtask

   task automatic do_clr();
      clr   = 1'b1;
      wr_en = 1'b1;   // must be ignored while clr is high
      din   = 8'hEE;
      @(posedge clk);
      #1;
      clr   = 1'b0;
      wr_en = 1'b0;
      model_clear();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rd;
      logic [4:0] e_cnt;
      logic [7:0] e_dout;
      logic       e_dv;
      logic       e_empty;
      logic       e_udf;
   } vec_t;

   vec_t tbl[9];

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      wr_en = 1'b0;
      din   = 8'h00;
      rd_en = 1'b0;
      exp_dout = 8'h00;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset_held");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("after_reset");

`ifdef FIFO_FWFT_EN
      // first-word-fall-through: word appears two edges after the write
      wr_en = 1'b1; din = 8'h3C;
      @(posedge clk); #1; wr_en = 1'b0;
      chk("fwft_e1.cnt",   32'(cnt),      32'd1);
      chk("fwft_e1.empty", 32'(empty),    32'd1);
      chk("fwft_e1.dv",    32'(dout_vld), 32'd0);
      @(posedge clk); #1;
      chk("fwft_e2.dout",  32'(dout),     32'h3C);
      chk("fwft_e2.dv",    32'(dout_vld), 32'd1);
      chk("fwft_e2.empty", 32'(empty),    32'd0);
      chk("fwft_e2.cnt",   32'(cnt),      32'd1);
      wr_en = 1'b1; din = 8'h4D;
      @(posedge clk); #1; wr_en = 1'b0;
      chk("fwft_w2.dout",  32'(dout),     32'h3C);
      chk("fwft_w2.cnt",   32'(cnt),      32'd2);
      rd_en = 1'b1;
      @(posedge clk); #1;
      chk("fwft_p1.dout",  32'(dout),     32'h4D);
      chk("fwft_p1.dv",    32'(dout_vld), 32'd1);
      chk("fwft_p1.cnt",   32'(cnt),      32'd1);
      @(posedge clk); #1;
      chk("fwft_p2.empty", 32'(empty),    32'd1);
      chk("fwft_p2.dv",    32'(dout_vld), 32'd0);
      chk("fwft_p2.cnt",   32'(cnt),      32'd0);
      chk("fwft_p2.udf",   32'(udf),      32'd0);
      @(posedge clk); #1; rd_en = 1'b0;
      chk("fwft_p3.udf",   32'(udf),      32'd1);
`else
      // hand-computed standard-mode sequence from a freshly reset FIFO
      tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 5'd1, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'h33, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 5'd1, 8'h22, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h33, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h33, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 8'hAA, 1'b1, 5'd1, 8'h33, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'hAA, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         wr_en = tbl[i].wr;
         din   = tbl[i].d;
         rd_en = tbl[i].rd;
         @(posedge clk);
         #1;
         wr_en = 1'b0;
         rd_en = 1'b0;
         chk($sformatf("vec%0d.cnt", i),   32'(cnt),      32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d.dout", i),  32'(dout),     32'(tbl[i].e_dout));
         chk($sformatf("vec%0d.dv", i),    32'(dout_vld), 32'(tbl[i].e_dv));
         chk($sformatf("vec%0d.empty", i), 32'(empty),    32'(tbl[i].e_empty));
         chk($sformatf("vec%0d.udf", i),   32'(udf),      32'(tbl[i].e_udf));
      end
      exp_dout = tbl[8].e_dout;
      do_clr();
      check_all("clr_after_table");

      // fill 0x01..0x10, drain in order
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         check_all($sformatf("fill%0d", i));
      end
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         check_all($sformatf("drain%0d", i));
      end

      // overflow while full, then flush
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
      check_all("full16");
      cycle(1'b1, 8'h99, 1'b0);
      check_all("ovf_write");
      do_clr();
      check_all("clr_after_ovf");

      // simultaneous read+write while full: 20 cycles, pointers wrap
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 8'(8'h40 + i), 1'b1);
         check_all($sformatf("rw_full%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         check_all($sformatf("rw_drain%0d", i));
      end

      // simultaneous read+write while empty
      cycle(1'b1, 8'hAA, 1'b1);
      check_all("rw_empty");
      cycle(1'b0, 8'h00, 1'b1);
      check_all("rw_empty_read");
      do_clr();

      // mixed traffic against the scoreboard
      for (int i = 0; i < 150; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         check_all($sformatf("mix%0d", i));
      end
      do_clr();
`endif

      // asynchronous reset mid-operation with 9 words stored
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      chk("pre_reset.cnt", 32'(cnt), 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      exp_dout = 8'h00;
      cycle(1'b1, 8'h55, 1'b0);
`ifdef FIFO_FWFT_EN
      @(posedge clk); #1;
      chk("post_reset.dout", 32'(dout), 32'h55);
      chk("post_reset.dv",   32'(dout_vld), 32'd1);
`else
      check_all("post_reset_write");
      cycle(1'b0, 8'h00, 1'b1);
      check_all("post_reset_read");
      chk("post_reset.dout", 32'(dout), 32'h55);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter WBITS, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4096, number of words; power of two, at least 4.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LVL, default 4, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have ports as follows; CW = clog2(DEPTH)+1:
 clk  in  1  single clock, rising edge.
 rst_n  in  1  asynchronous active-low reset.
 clr  in  1  synchronous flush; clears pointers and sticky flags.
 wr_en  in  1  write request.
 din  in  WBITS  write data.
 rd_en  in  1  read request (pop).
 dout  out  WBITS  read data.
 dout_vld  out  1  dout holds a newly read word.
 empty  out  1  no readable word.
 full  out  1  DEPTH words stored.
 almost_full  out  1  occupancy >= AF_LVL.
 almost_empty  out  1  occupancy <= AE_LVL.
 cnt  out  CW  occupancy, 0..DEPTH inclusive.
 ovf  out  1  sticky overflow: write refused.
 udf  out  1  sticky underflow: read refused.

Function
REQ-006 SHALL use CW-bit head/tail pointers; the MSB distinguishes full from empty; cnt = head - tail modulo 2^CW.
REQ-007 SHALL accept a write when wr_en=1 and (full=0, or a read is accepted in the same cycle).
REQ-008 SHALL accept a read when rd_en=1 and empty=0.
REQ-009 SHALL update cnt on the same edge as pointers: +1 write only, -1 read only, unchanged for both or neither.
REQ-010 SHALL register empty, full, almost_full and almost_empty, all consistent with cnt in every cycle.
REQ-011 SHALL wrap pointers from DEPTH-1 to 0 with no lost or duplicated word.
REQ-012 SHALL set ovf on wr_en=1 with the write refused, and set udf on rd_en=1 with the read refused.
REQ-013 SHALL hold ovf and udf until clr or reset.
REQ-014 SHALL, at empty with rd_en and wr_en both 1, accept the write, refuse the read and set udf.
REQ-015 SHALL, at full with rd_en and wr_en both 1, accept both and keep full=1.
REQ-016 SHALL, in standard mode, present the word on dout one cycle after the read is accepted, pulse dout_vld for that cycle, and hold dout otherwise.
REQ-017 SHALL have clr take priority over wr_en and rd_en in the same cycle; memory contents are don't-care after clr.

Reset
REQ-018 SHALL, on rst_n=0, immediately clear pointers, cnt, dout, dout_vld, full, almost_full, ovf and udf to 0, and set empty=1 and almost_empty=1.
REQ-019 SHALL, on reset mid-operation, discard all stored words; the first write after rst_n deasserts is the first word read.
REQ-020 SHALL not require the memory array to be reset.

Configuration
REQ-021 SHALL, with FIFO_FWFT_EN defined, run first-word-fall-through: dout shows the oldest word whenever empty=0, dout_vld = !empty, and rd_en pops that word.
REQ-022 SHALL, with FIFO_FWFT_EN defined, deassert empty two edges after the first write into an empty FIFO (prefetch register); cnt includes the prefetched word.
REQ-023 SHALL, without FIFO_FWFT_EN, run standard mode as in REQ-016, with empty deasserting one edge after the write.

Structure
REQ-024 SHALL put in package fifo_pkg: the pointer-width function, the default level constants, and a status struct typedef (empty, full, almost_full, almost_empty, ovf, udf).
REQ-025 SHALL put storage in sub-module fifo_ram: simple dual-port, synchronous write, registered read, WBITS x DEPTH, inferable as block RAM.

Verification (WBITS=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
REQ-026 SHALL cover: reset, then write 0x01..0x10 -> full=1, cnt=16, almost_full=1 from cnt=14, reads return 0x01..0x10 in order, then empty=1.
REQ-027 SHALL cover: 17th write while full -> data dropped, ovf=1, cnt stays 16; clr -> ovf=0, cnt=0, empty=1.
REQ-028 SHALL cover: rd_en and wr_en together while full for 20 cycles -> full stays 1, output stream has no gaps, pointers wrap past 15.
REQ-029 SHALL cover: rd_en and wr_en together while empty with din=0xAA -> cnt=1, udf=1, next read returns 0xAA.
REQ-030 SHALL cover: rst_n pulled low with cnt=9 -> all outputs at reset values within the cycle; write 0x55 then read -> 0x55.
REQ-031 SHALL cover: with FIFO_FWFT_EN, write 0x3C into an empty FIFO -> dout=0x3C with dout_vld=1 two edges later, before any rd_en.
